// File: rtl/gcn_aggregate_argmax.sv
`default_nettype none
// ============================================================================
//  Module      : gcn_aggregate_argmax
//  Description : Aggregates the transformed feature matrix H over an undirected
//                COO edge list (AGG = (A + I) * H, one edge per cycle), then
//                reduces every AGG row to the column index of its maximum.
//  Revision    : 1.0 - initial release
// ============================================================================
module gcn_aggregate_argmax #(
  parameter int FEATURE_ROWS      = 6,
  parameter int WEIGHT_COLS       = 3,
  parameter int DOT_PROD_WIDTH    = 16,
  parameter int NUM_OF_NODES      = 6,
  parameter int COO_NUM_OF_COLS   = 6,
  parameter int COO_BW            = $clog2(COO_NUM_OF_COLS),
  parameter int MAX_ADDRESS_WIDTH = 2
) (
  input  logic                                                      clk,
  input  logic                                                      reset,
  input  logic                                                      start,
  input  logic [FEATURE_ROWS-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] fm_wm_in,
  output logic [COO_BW-1:0]                                         coo_address,
  input  logic [2*COO_BW-1:0]                                       coo_in,
  output logic                                                      done,
  output logic [FEATURE_ROWS-1:0][MAX_ADDRESS_WIDTH-1:0]            max_addi_answer,
  output logic                                                      edge_error
);

  localparam int ROW_BW = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
  localparam logic [COO_BW-1:0] C_LAST_EDGE = COO_BW'(COO_NUM_OF_COLS - 1);
  localparam logic [ROW_BW-1:0] C_LAST_ROW  = ROW_BW'(FEATURE_ROWS - 1);
  localparam logic [COO_BW:0]   C_MAX_NODE  = (COO_BW + 1)'(NUM_OF_NODES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_EDGE   = 3'd2,
    S_ARGMAX = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [COO_BW-1:0] r_edge_cnt;
  logic [ROW_BW-1:0] r_row_cnt;
  logic [FEATURE_ROWS-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] r_agg;

  logic [COO_BW-1:0] w_src;
  logic [COO_BW-1:0] w_dst;
  logic              w_edge_valid;
  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] w_h_src;
  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] w_h_dst;
  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] w_arg_row;
  logic [DOT_PROD_WIDTH-1:0]    w_best_val;
  logic [MAX_ADDRESS_WIDTH-1:0] w_best_idx;

  // The edge index only leaves the block while edges are being walked.
  assign coo_address = (r_state == S_EDGE) ? r_edge_cnt : '0;

  // Decode the current edge and fetch the H rows of both endpoints (ids are 1-based).
  always_comb begin
    w_src        = coo_in[2*COO_BW-1:COO_BW];
    w_dst        = coo_in[COO_BW-1:0];
    w_edge_valid = (w_src != '0) && (w_dst != '0) &&
                   ({1'b0, w_src} <= C_MAX_NODE) && ({1'b0, w_dst} <= C_MAX_NODE);
    w_h_src      = '0;
    w_h_dst      = '0;
    for (int i = 0; i < FEATURE_ROWS; i++) begin
      if (COO_BW'(i + 1) == w_src) w_h_src = fm_wm_in[i];
      if (COO_BW'(i + 1) == w_dst) w_h_dst = fm_wm_in[i];
    end
  end

  // Argmax of the row currently addressed; strict compare keeps the lowest column on ties.
  always_comb begin
    w_arg_row = '0;
    for (int i = 0; i < FEATURE_ROWS; i++) begin
      if (ROW_BW'(i) == r_row_cnt) w_arg_row = r_agg[i];
    end
    w_best_val = w_arg_row[0];
    w_best_idx = '0;
    for (int c = 1; c < WEIGHT_COLS; c++) begin
      if (w_arg_row[c] > w_best_val) begin
        w_best_val = w_arg_row[c];
        w_best_idx = MAX_ADDRESS_WIDTH'(c);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state sequencing: one pass through aggregate then argmax per accepted start.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next_state = S_INIT;
      S_INIT:   w_next_state = S_EDGE;
      S_EDGE:   if (r_edge_cnt == C_LAST_EDGE) w_next_state = S_ARGMAX;
      S_ARGMAX: if (r_row_cnt == C_LAST_ROW) w_next_state = S_DONE;
      S_DONE:   if (!start) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Datapath: self-loop load, per-edge accumulation (mod 2^W), row-wise argmax, status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_agg           <= '0;
      r_edge_cnt      <= '0;
      r_row_cnt       <= '0;
      done            <= 1'b0;
      edge_error      <= 1'b0;
      max_addi_answer <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) edge_error <= 1'b0;
        end
        S_INIT: begin
          r_agg      <= fm_wm_in;
          r_edge_cnt <= '0;
          r_row_cnt  <= '0;
        end
        S_EDGE: begin
          if (w_edge_valid) begin
            // A self-edge matches the first branch only, so it is added exactly once.
            for (int i = 0; i < FEATURE_ROWS; i++) begin
              if (COO_BW'(i + 1) == w_src) begin
                for (int c = 0; c < WEIGHT_COLS; c++)
                  r_agg[i][c] <= r_agg[i][c] + w_h_dst[c];
              end else if (COO_BW'(i + 1) == w_dst) begin
                for (int c = 0; c < WEIGHT_COLS; c++)
                  r_agg[i][c] <= r_agg[i][c] + w_h_src[c];
              end
            end
          end else begin
            edge_error <= 1'b1;
          end
          r_edge_cnt <= r_edge_cnt + COO_BW'(1);
        end
        S_ARGMAX: begin
          for (int i = 0; i < FEATURE_ROWS; i++) begin
            if (ROW_BW'(i) == r_row_cnt) max_addi_answer[i] <= w_best_idx;
          end
          r_row_cnt <= r_row_cnt + ROW_BW'(1);
          if (r_row_cnt == C_LAST_ROW) done <= 1'b1;
        end
        S_DONE: begin
          if (!start) done <= 1'b0;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gcn_aggregate_argmax.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gcn_aggregate_argmax
//  Description : Directed bench for gcn_aggregate_argmax with an edge-walk
//                reference model and hand-computed answer literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gcn_aggregate_argmax;

  localparam int FR = 6;
  localparam int WC = 3;
  localparam int W  = 16;
  localparam int NN = 6;
  localparam int NE = 6;
  localparam int BW = 3;
  localparam int MW = 2;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [FR-1:0][WC-1:0][W-1:0] fm_wm_in;
  logic [BW-1:0]                coo_address;
  logic [2*BW-1:0]              coo_in;
  logic                         done;
  logic [FR-1:0][MW-1:0]        max_addi_answer;
  logic                         edge_error;

  logic [2*BW-1:0] coo_mem [0:7];

  int tests = 0;
  int fails = 0;
  int n     = 0;
  bit track = 1'b0;

  logic [W-1:0]  m_agg [FR][WC];
  logic [MW-1:0] m_ans [FR];
  bit            m_err;

  gcn_aggregate_argmax #(
    .FEATURE_ROWS(FR), .WEIGHT_COLS(WC), .DOT_PROD_WIDTH(W), .NUM_OF_NODES(NN),
    .COO_NUM_OF_COLS(NE), .COO_BW(BW), .MAX_ADDRESS_WIDTH(MW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .fm_wm_in(fm_wm_in),
    .coo_address(coo_address), .coo_in(coo_in), .done(done),
    .max_addi_answer(max_addi_answer), .edge_error(edge_error)
  );

  always #5 clk = ~clk;

  // COO memory answers combinationally.
  assign coo_in = coo_mem[coo_address];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: start from H (self loops), add neighbour rows per valid edge, then argmax.
  function automatic void model();
    int s, d;
    m_err = 1'b0;
    for (int i = 0; i < FR; i++)
      for (int c = 0; c < WC; c++) m_agg[i][c] = fm_wm_in[i][c];
    for (int k = 0; k < NE; k++) begin
      s = int'(coo_mem[k][2*BW-1:BW]);
      d = int'(coo_mem[k][BW-1:0]);
      if (s < 1 || s > NN || d < 1 || d > NN) m_err = 1'b1;
      else begin
        for (int c = 0; c < WC; c++) begin
          m_agg[s-1][c] = m_agg[s-1][c] + fm_wm_in[d-1][c];
          if (s != d) m_agg[d-1][c] = m_agg[d-1][c] + fm_wm_in[s-1][c];
        end
      end
    end
    for (int i = 0; i < FR; i++) begin
      m_ans[i] = '0;
      for (int c = 1; c < WC; c++)
        if (m_agg[i][c] > m_agg[i][int'(m_ans[i])]) m_ans[i] = MW'(c);
    end
  endfunction

  task automatic set_edge(input int k, input int s, input int d);
    coo_mem[k] = {BW'(s), BW'(d)};
  endtask

  task automatic load_ring();
    set_edge(0, 1, 2); set_edge(1, 2, 3); set_edge(2, 3, 4);
    set_edge(3, 4, 5); set_edge(4, 5, 6); set_edge(5, 6, 1);
  endtask

  // Posedges since start was accepted (1 = accept edge itself has passed).
  always @(posedge clk) if (track) n = n + 1;

  // Per-cycle check of the handshake outputs while a run is in flight.
  always @(negedge clk) begin
    if (track && reset && n >= 1) begin
      chk("coo_address", int'(coo_address), (n >= 2 && n <= 1 + NE) ? n - 2 : 0);
      chk("done_timing", int'(done), (n >= 2 + NE + FR) ? 1 : 0);
      if (n == 1) chk("edge_error_clear_at_accept", int'(edge_error), 0);
    end
  end

  task automatic run(input string name, input logic [FR*MW-1:0] lit, input bit lit_err);
    model();
    @(negedge clk);
    start = 1'b1;
    n     = 0;
    track = 1'b1;
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    chk({name, " latency"}, n, 2 + NE + FR);
    for (int i = 0; i < FR; i++)
      chk($sformatf("%s ans[%0d]", name, i), int'(max_addi_answer[i]), int'(m_ans[i]));
    chk({name, " edge_error_model"}, int'(edge_error), int'(m_err));
    chk({name, " answers_literal"}, int'(max_addi_answer), int'(lit));
    chk({name, " edge_error_literal"}, int'(edge_error), int'(lit_err));
    repeat (3) @(negedge clk);
    chk({name, " answers_held"}, int'(max_addi_answer), int'(lit));
    start = 1'b0;
    track = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({name, " done_drop"}, int'(done), 0);
    chk({name, " answers_after_drop"}, int'(max_addi_answer), int'(lit));
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b1;
    fm_wm_in = '0;
    for (int k = 0; k < 8; k++) coo_mem[k] = '0;

    // T1 reset held with start high
    repeat (3) @(negedge clk);
    chk("T1 done", int'(done), 0);
    chk("T1 coo_address", int'(coo_address), 0);
    chk("T1 edge_error", int'(edge_error), 0);
    chk("T1 answers", int'(max_addi_answer), 0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // T2 ring
    fm_wm_in = '0;
    fm_wm_in[0][0] = 16'd10;
    for (int i = 1; i < FR; i++) fm_wm_in[i][2] = 16'd1;
    load_ring();
    run("T2", {2'd0, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0}, 1'b0);

    // T3 repeated self loop
    fm_wm_in = '0;
    fm_wm_in[2][1] = 16'd5;
    for (int k = 0; k < NE; k++) set_edge(k, 3, 3);
    run("T3", {2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0}, 1'b0);

    // T4 modular wrap
    fm_wm_in = '0;
    fm_wm_in[0][0] = 16'h8000;
    fm_wm_in[0][2] = 16'd1;
    set_edge(0, 1, 1);
    for (int k = 1; k < NE; k++) set_edge(k, 2, 2);
    run("T4", {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2}, 1'b0);

    // T5 invalid id 0, then clean restart
    fm_wm_in = '0;
    fm_wm_in[2][2] = 16'd9;
    set_edge(0, 0, 3);
    for (int k = 1; k < NE; k++) set_edge(k, 1, 2);
    run("T5", {2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0}, 1'b1);
    load_ring();
    run("T5b", {2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0}, 1'b0);

    // T7 invalid id above node count
    fm_wm_in = '0;
    fm_wm_in[0][1] = 16'd3;
    set_edge(0, 7, 1);
    for (int k = 1; k < NE; k++) set_edge(k, 1, 2);
    run("T7", {2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1}, 1'b1);

    // T6 abort mid-run, then repeat T2
    fm_wm_in = '0;
    fm_wm_in[0][0] = 16'd10;
    for (int i = 1; i < FR; i++) fm_wm_in[i][2] = 16'd1;
    load_ring();
    @(negedge clk);
    start = 1'b1;
    n     = 0;
    track = 1'b1;
    repeat (5) @(negedge clk);
    track = 1'b0;
    reset = 1'b0;
    #1;
    chk("T6 done", int'(done), 0);
    chk("T6 coo_address", int'(coo_address), 0);
    chk("T6 answers", int'(max_addi_answer), 0);
    chk("T6 edge_error", int'(edge_error), 0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run("T6", {2'd0, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0}, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
